// File: rtl/amiga_clk_pkg.sv
// amiga_clk_pkg: shared types and constants for the Amiga clock/reset sequencer.
// Holds the FSM encoding, 7 MHz phase slots and E-clock counter limits.
package amiga_clk_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } clk_state_e;

  localparam logic [1:0] PH_CLK7  = 2'd3;
  localparam logic [1:0] PH_CLK7N = 2'd1;

  localparam logic [3:0] ECLK_LAST       = 4'd9;
  localparam logic [3:0] ECLK_HIGH_START = 4'd6;

  // Width of the shared sequencer counter: must hold the largest parameter.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/amiga_sync2.sv
// amiga_sync2: generic two-flop synchronizer, asynchronous reset to 0.
module amiga_sync2 (
  input  logic clk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/amiga_clk_ctrl.sv
// amiga_clk_ctrl: PLL lock supervisor, 7 MHz enables and system reset release.
// Define AMIGA_CLK_CTRL_ECLK_EN to build the 68000 E-clock generator.
module amiga_clk_ctrl #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 4096
) (
  input  logic clk,
  input  logic areset,
  input  logic pll_locked,
  input  logic soft_rst,
  output logic pll_rst,
  output logic sys_rst,
  output logic ready,
  output logic clk7_en,
  output logic clk7n_en,
  output logic eclk,
  output logic eclk_tick
);

  import amiga_clk_pkg::*;

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);

  logic lock_s;

  amiga_sync2 u_lock_sync (
    .clk    (clk),
    .areset (areset),
    .d      (pll_locked),
    .q      (lock_s)
  );

  clk_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic          clk7_en_q, clk7_en_d;
  logic          clk7n_en_q, clk7n_en_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;

  always_comb begin
    phase_d    = phase_q + 2'd1;
    clk7_en_d  = (phase_d == PH_CLK7);
    clk7n_en_d = (phase_d == PH_CLK7N);
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    unique case (state_q)
      ST_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) state_d = ST_STABLE;
        else if (cnt_q == TMO_LAST) state_d = ST_PLLRST;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (soft_rst) begin
          cnt_d = '0;
        end else if (cnt_q == STB_LAST) begin
          // Hold the full count until the 7 MHz slot lines up.
          cnt_d = cnt_q;
          if (clk7_en_d) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) state_d = ST_PLLRST;
        else if (soft_rst) state_d = ST_STABLE;
      end
      default: state_d = ST_PLLRST;
    endcase
    if (state_d != state_q) cnt_d = '0;
    pll_rst_d = (state_d == ST_PLLRST);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_PLLRST;
      cnt_q      <= '0;
      phase_q    <= 2'd0;
      clk7_en_q  <= 1'b0;
      clk7n_en_q <= 1'b0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      clk7_en_q  <= clk7_en_d;
      clk7n_en_q <= clk7n_en_d;
      pll_rst_q  <= pll_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
    end
  end

  assign pll_rst  = pll_rst_q;
  assign sys_rst  = sys_rst_q;
  assign ready    = ready_q;
  assign clk7_en  = clk7_en_q;
  assign clk7n_en = clk7n_en_q;

`ifdef AMIGA_CLK_CTRL_ECLK_EN
  logic [3:0] ecnt_q, ecnt_d;
  logic       eclk_q, eclk_d;
  logic       eclk_tick_q, eclk_tick_d;

  // Outputs are computed from next-state values so they stay registered.
  always_comb begin
    ecnt_d = ecnt_q;
    if (sys_rst_d) ecnt_d = 4'd0;
    else if (clk7_en_q)
      ecnt_d = (ecnt_q == ECLK_LAST) ? 4'd0 : ecnt_q + 4'd1;
    eclk_d      = (ecnt_d >= ECLK_HIGH_START);
    eclk_tick_d = !sys_rst_d && clk7_en_d &&
                  (ecnt_d == ECLK_HIGH_START - 4'd1);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ecnt_q      <= 4'd0;
      eclk_q      <= 1'b0;
      eclk_tick_q <= 1'b0;
    end else begin
      ecnt_q      <= ecnt_d;
      eclk_q      <= eclk_d;
      eclk_tick_q <= eclk_tick_d;
    end
  end

  assign eclk      = eclk_q;
  assign eclk_tick = eclk_tick_q;
`else
  assign eclk      = 1'b0;
  assign eclk_tick = 1'b0;
`endif

endmodule

// File: tb/tb_amiga_clk_ctrl.sv
// tb_amiga_clk_ctrl: scenario bench for amiga_clk_ctrl (params 16/256/64).
`timescale 1ns/1ps
module tb_amiga_clk_ctrl;

  localparam int P_RST = 16;
  localparam int P_TMO = 256;
  localparam int P_STB = 64;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic pll_locked = 1'b0;
  logic soft_rst = 1'b0;
  logic pll_rst, sys_rst, ready, clk7_en, clk7n_en, eclk, eclk_tick;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  amiga_clk_ctrl #(
    .PLL_RST_CYCLES     (P_RST),
    .LOCK_TIMEOUT       (P_TMO),
    .LOCK_STABLE_CYCLES (P_STB)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .clk7_en    (clk7_en),
    .clk7n_en   (clk7n_en),
    .eclk       (eclk),
    .eclk_tick  (eclk_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    pll_locked = 1'b1;
    soft_rst = 1'b0;
    step(3);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
    total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL rst_sys_rst got=%b exp=1", sys_rst); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
    total++; if (clk7_en !== 1'b0) begin bad++; $display("FAIL rst_clk7_en got=%b exp=0", clk7_en); end
    total++; if (clk7n_en !== 1'b0) begin bad++; $display("FAIL rst_clk7n_en got=%b exp=0", clk7n_en); end
    total++; if (eclk !== 1'b0) begin bad++; $display("FAIL rst_eclk got=%b exp=0", eclk); end
    total++; if (eclk_tick !== 1'b0) begin bad++; $display("FAIL rst_eclk_tick got=%b exp=0", eclk_tick); end
  endtask

  // Releases areset with lock held; checks pll_rst width and release point.
  task automatic boot_seq(input string tag);
    int n, e;
    exp_q.push_back(P_RST);
    exp_q.push_back(P_STB + 3);
    areset = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 1000) begin n++; step(); end
    e = exp_q.pop_front();
    total++; if (n !== e) begin bad++; $display("FAIL %s_pll_rst_len got=%0d exp=%0d", tag, n, e); end
    n = 0;
    while (sys_rst === 1'b1 && n < 1000) begin n++; step(); end
    e = exp_q.pop_front();
    total++; if (n !== e) begin bad++; $display("FAIL %s_release got=%0d exp=%0d", tag, n, e); end
    total++; if (clk7_en !== 1'b1) begin bad++; $display("FAIL %s_rel_clk7 got=%b exp=1", tag, clk7_en); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", tag, ready); end
  endtask

  task automatic test_boot();
    boot_seq("boot");
  endtask

  task automatic test_clk7();
    int q7[$];
    int q7n[$];
    int n7, n7n, e;
    n7 = 0;
    n7n = 0;
    for (int t = 0; t < 40; t++) begin
      if (clk7_en === 1'b1) begin
        n7++;
        if (q7.size() > 0) begin
          e = q7.pop_front();
          total++; if (t !== e) begin bad++; $display("FAIL clk7_period got=%0d exp=%0d", t, e); end
        end
        q7.push_back(t + 4);
        q7n.push_back(t + 2);
      end
      if (clk7n_en === 1'b1) begin
        n7n++;
        if (q7n.size() > 0) begin
          e = q7n.pop_front();
          total++; if (t !== e) begin bad++; $display("FAIL clk7n_offset got=%0d exp=%0d", t, e); end
        end
      end
      step();
    end
    total++; if (n7 !== 10) begin bad++; $display("FAIL clk7_count got=%0d exp=10", n7); end
    total++; if (n7n !== 10) begin bad++; $display("FAIL clk7n_count got=%0d exp=10", n7n); end
  endtask

  task automatic test_soft_rst();
    int n, e, k;
    step(3);
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    n = 0;
    while (sys_rst === 1'b1 && n < 1000) begin n++; step(); end
    total++; if (n < P_STB || n > P_STB + 3) begin bad++; $display("FAIL soft_hold got=%0d exp=64..67", n); end
    total++; if (clk7_en !== 1'b1) begin bad++; $display("FAIL soft_rel_clk7 got=%b exp=1", clk7_en); end
`ifdef AMIGA_CLK_CTRL_ECLK_EN
    exp_q.push_back(6);
    exp_q.push_back(16);
    exp_q.push_back(24);
    k = 0;
    n = 0;
    while (eclk_tick !== 1'b1 && n < 200) begin
      if (clk7_en === 1'b1) k++;
      n++;
      step();
    end
    if (clk7_en === 1'b1) k++;
    e = exp_q.pop_front();
    total++; if (k !== e) begin bad++; $display("FAIL eclk_first_tick got=%0d exp=%0d", k, e); end
    step();
    total++; if (eclk_tick !== 1'b0) begin bad++; $display("FAIL eclk_tick_width got=%b exp=0", eclk_tick); end
    n = 0;
    while (eclk === 1'b1 && n < 100) begin n++; step(); end
    e = exp_q.pop_front();
    total++; if (n !== e) begin bad++; $display("FAIL eclk_high got=%0d exp=%0d", n, e); end
    n = 0;
    while (eclk === 1'b0 && n < 100) begin n++; step(); end
    e = exp_q.pop_front();
    total++; if (n !== e) begin bad++; $display("FAIL eclk_low got=%0d exp=%0d", n, e); end
`else
    exp_q.push_back(0);
    k = 0;
    for (int t = 0; t < 100; t++) begin
      if (eclk !== 1'b0 || eclk_tick !== 1'b0) k++;
      step();
    end
    e = exp_q.pop_front();
    total++; if (k !== e) begin bad++; $display("FAIL eclk_tied got=%0d exp=%0d", k, e); end
`endif
  endtask

  // Second soft_rst while still in STABLE must restart the stable count.
  task automatic test_back_to_back();
    int n, ne;
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    step(19);
    total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL b2b_in_stable got=%b exp=1", sys_rst); end
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    n = 0;
    ne = 0;
    while (sys_rst === 1'b1 && n < 1000) begin
      if (eclk !== 1'b0) ne++;
      n++;
      step();
    end
    total++; if (n < P_STB || n > P_STB + 3) begin bad++; $display("FAIL b2b_hold got=%0d exp=64..67", n); end
    total++; if (ne !== 0) begin bad++; $display("FAIL b2b_eclk_in_rst got=%0d exp=0", ne); end
    total++; if (clk7_en !== 1'b1) begin bad++; $display("FAIL b2b_rel_clk7 got=%b exp=1", clk7_en); end
  endtask

  task automatic test_lock_loss();
    int n, e;
    step(5);
    exp_q.push_back(3);
    exp_q.push_back(P_RST);
    pll_locked = 1'b0;
    n = 0;
    while (!(sys_rst === 1'b1 && pll_rst === 1'b1) && n < 50) begin n++; step(); end
    e = exp_q.pop_front();
    total++; if (n !== e) begin bad++; $display("FAIL loss_latency got=%0d exp=%0d", n, e); end
    pll_locked = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 1000) begin n++; step(); end
    e = exp_q.pop_front();
    total++; if (n !== e) begin bad++; $display("FAIL loss_pll_rst_len got=%0d exp=%0d", n, e); end
    n = 0;
    while (sys_rst === 1'b1 && n < 1000) begin n++; step(); end
    total++; if (n < P_STB + 1 || n > P_STB + 4) begin bad++; $display("FAIL loss_release got=%0d exp=65..68", n); end
    total++; if (clk7_en !== 1'b1) begin bad++; $display("FAIL loss_rel_clk7 got=%b exp=1", clk7_en); end
  endtask

  task automatic test_areset_mid();
    logic [6:0] o;
    step();
    #2 areset = 1'b1;
    #1 o = {pll_rst, sys_rst, ready, clk7_en, clk7n_en, eclk, eclk_tick};
    total++; if (o !== 7'b1100000) begin bad++; $display("FAIL areset_async got=%b exp=1100000", o); end
    step();
    boot_seq("rearm");
  endtask

  task automatic test_glitch();
    int n, e, np;
    areset = 1'b1;
    pll_locked = 1'b1;
    step(2);
    areset = 1'b0;
    step(45);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    exp_q.push_back(69);
    n = 0;
    np = 0;
    while (sys_rst === 1'b1 && n < 1000) begin
      if (pll_rst !== 1'b0) np++;
      n++;
      step();
    end
    e = exp_q.pop_front();
    total++; if (n !== e) begin bad++; $display("FAIL glitch_release got=%0d exp=%0d", n, e); end
    total++; if (np !== 0) begin bad++; $display("FAIL glitch_pll_rst got=%0d exp=0", np); end
  endtask

  task automatic test_no_lock();
    int n, e, nsys, n7;
    logic lvl;
    areset = 1'b1;
    pll_locked = 1'b0;
    step(2);
    exp_q.push_back(P_RST);
    exp_q.push_back(P_TMO);
    exp_q.push_back(P_RST);
    exp_q.push_back(P_TMO);
    areset = 1'b0;
    nsys = 0;
    n7 = 0;
    for (int k = 0; k < 4; k++) begin
      lvl = (k % 2 == 0);
      n = 0;
      while (pll_rst === lvl && n < 1000) begin
        if (sys_rst !== 1'b1) nsys++;
        if (k == 0 && clk7_en === 1'b1) n7++;
        n++;
        step();
      end
      e = exp_q.pop_front();
      total++; if (n !== e) begin bad++; $display("FAIL nolock_seg%0d got=%0d exp=%0d", k, n, e); end
    end
    total++; if (nsys !== 0) begin bad++; $display("FAIL nolock_sys_rst got=%0d exp=0", nsys); end
    total++; if (n7 !== 4) begin bad++; $display("FAIL nolock_clk7_in_rst got=%0d exp=4", n7); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_clk7();
    test_soft_rst();
    test_back_to_back();
    test_lock_loss();
    test_areset_mid();
    test_glitch();
    test_no_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
